md_unit: RTL
============

# md_unit

Multiply/divide unit for the next-generation pipelined MIPS core; sits in the E stage beside the ALU and owns the HI/LO register pair. It accepts a mult/div/mthi/mtlo operation from the E-stage controls and holds `busy` for a parametrised number of cycles. It then commits the result to HI/LO. The hazard unit stalls D-stage mult/div/mfhi/mflo instructions on `start | busy`.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU/MADD*/MSUB*; legal range 1..15.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU; legal range 1..31.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; takes effect on the rising edge of `clk`.
- `start`  in  1  E-stage instruction is an MD op; qualified by `md_op`.
- `md_op`  in  4  operation code; encodings live in `md_pkg`.
- `a`  in  WIDTH  rs operand, forwarded.
- `b`  in  WIDTH  rt operand, forwarded.
- `busy`  out  1  operation in progress.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- Op codes: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU. Any other code is treated as NONE.
- States: IDLE and RUN. A 5-bit down-counter `cnt` tracks RUN.
- IDLE, `start`, multi-cycle op:
  - Latch the result into `pend_hi`/`pend_lo`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- IDLE, `start`, MTHI: `hi <= a` on that edge. MTLO: `lo <= a` on that edge. Neither sets `busy`.
- RUN: `cnt` decrements each cycle. On the edge where `cnt == 1`, `{hi,lo} <= {pend_hi,pend_lo}` and the block returns to IDLE.
- `start` while RUN is illegal and is ignored: HI/LO and the counter are unaffected. The bench flags it with an assertion.
- Multiply results:
  - MULT gives `{hi,lo} = $signed(a)*$signed(b)`, 2*WIDTH bits.
  - MULTU gives the unsigned product.
- Multiply-accumulate results, computed from HI/LO at the start edge, modulo 2^(2*WIDTH):
  - MADD/MADDU: `{hi,lo} + product`.
  - MSUB/MSUBU: `{hi,lo} - product`.
- DIV: `lo` = quotient truncated toward zero; `hi` = remainder, which takes the sign of the dividend.
- DIVU: unsigned quotient in `lo`, unsigned remainder in `hi`.
- Divide by zero (DIV and DIVU): `lo = {WIDTH{1'b1}}`, `hi = a`.
- DIV overflow (a = most-negative value, b = -1): `lo = a`, `hi = 0`.
- Reset: `hi = 0`, `lo = 0`, `busy = 0`, state IDLE, `cnt = 0`, pending result discarded. This applies even mid-RUN.

## Timing
- `busy` is registered. It is high for exactly N cycles, starting the cycle after the `start` edge, where N is MULT_CYCLES or DIV_CYCLES.
- New HI/LO are visible the cycle after the last busy cycle.
- A `start` on the cycle right after `busy` falls is accepted.
- MTHI/MTLO: the new value is visible on the next cycle. Zero stall.
- `hi`/`lo` are register outputs. There is no combinational path from the inputs to them.
- Reset asserted on the same edge as `start`: reset wins and the op is dropped.

## Configuration
- `MDU_MADD_EN` defined: MADD, MADDU, MSUB and MSUBU are executed as specified above.
- `MDU_MADD_EN` undefined: codes 7..10 decode as NONE. No state change, no `busy`, and the accumulate adder is not synthesised.

## Structure
- `md_pkg` holds:
  - the `md_op_t` enum (4 bits) with the codes above;
  - default cycle-count localparams;
  - `CNT_W = 5`.
- Sub-module `md_divider`: combinational signed/unsigned divider. It takes WIDTH-bit `a`, `b` and `sign`, and returns quotient and remainder with the divide-by-zero and overflow rules built in. `md_unit` instantiates it once.
- Multiplication is inline in `md_unit`.

## Test plan
- MULT a=0xFFFFFFFF, b=2: `busy` is high for exactly 5 cycles, then `hi=0xFFFFFFFF`, `lo=0xFFFFFFFE`. MULTU with the same operands gives `hi=0x00000001`, `lo=0xFFFFFFFE`.
- DIV a=0xFFFFFFF9 (-7), b=2: after 10 busy cycles `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`. DIVU a=7, b=2 gives `lo=3`, `hi=1`.
- DIV with b=0, a=0x12345678: `lo=0xFFFFFFFF`, `hi=0x12345678`. DIV a=0x80000000, b=0xFFFFFFFF: `lo=0x80000000`, `hi=0`.
- MTHI a=0xA5A5A5A5: `hi` updates on the next cycle and `busy` stays 0. A second MULT issued while `busy=1` leaves the result of the first op intact.
- Reset mid-DIV (cycle 4 of 10): the next cycle shows `busy=0`, `hi=lo=0`, and no late commit.
- With `MDU_MADD_EN`, after MULT 3*4, MADD 2*5 gives `lo=22`, `hi=0`, and MSUBU 1*1 then gives `lo=21`. Without the macro, MADD leaves `lo=12` and `busy=0`.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and defaults for the multiply/divide unit.
// MDU_MADD_EN enables decoding of the MADD/MADDU/MSUB/MSUBU accumulate ops.
package md_pkg;

  localparam int unsigned CNT_W           = 5;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  typedef struct packed {
    logic mul;
    logic div;
    logic sgn;
    logic mthi;
    logic mtlo;
`ifdef MDU_MADD_EN
    logic acc;
    logic sub;
`endif
  } md_dec_t;

  // Unknown codes (and accumulate codes when disabled) decode to all-zero, i.e. NONE.
  function automatic md_dec_t md_decode(input logic [3:0] op);
    md_dec_t d;
    d = '0;
    case (op)
      OP_MULT:  begin d.mul = 1'b1; d.sgn = 1'b1; end
      OP_MULTU: d.mul  = 1'b1;
      OP_DIV:   begin d.div = 1'b1; d.sgn = 1'b1; end
      OP_DIVU:  d.div  = 1'b1;
      OP_MTHI:  d.mthi = 1'b1;
      OP_MTLO:  d.mtlo = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin d.mul = 1'b1; d.acc = 1'b1; d.sgn = 1'b1; end
      OP_MADDU: begin d.mul = 1'b1; d.acc = 1'b1; end
      OP_MSUB:  begin d.mul = 1'b1; d.acc = 1'b1; d.sub = 1'b1; d.sgn = 1'b1; end
      OP_MSUBU: begin d.mul = 1'b1; d.acc = 1'b1; d.sub = 1'b1; end
`endif
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/md_divider.sv
// Combinational signed/unsigned divider with MIPS divide-by-zero and overflow results.
module md_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;

  // Divide magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend.
  always_comb begin
    a_neg = sign & a[WIDTH-1];
    b_neg = sign & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    uq    = a_mag / b_mag;
    ur    = a_mag % b_mag;
    if (b == '0) begin
      quot = '1;
      rem  = a;
    end else if (sign && (a == MIN_NEG) && (b == '1)) begin
      quot = a;
      rem  = '0;
    end else begin
      quot = (a_neg ^ b_neg) ? -uq : uq;
      rem  = a_neg ? -ur : ur;
    end
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO; multi-cycle ops hold busy, then commit.
// MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate path.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned PW = 2 * WIDTH;

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             busy_q, busy_d;

  md_dec_t          dec;
  logic [PW-1:0]    mul_a;
  logic [PW-1:0]    mul_b;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    mul_res;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] div_rem;

  assign dec = md_decode(md_op);

  // Sign/zero-extend to 2*WIDTH; the low 2*WIDTH product bits are then exact for both.
  always_comb begin
    mul_a = {{WIDTH{dec.sgn & a[WIDTH-1]}}, a};
    mul_b = {{WIDTH{dec.sgn & b[WIDTH-1]}}, b};
    prod  = mul_a * mul_b;
  end

`ifdef MDU_MADD_EN
  logic [PW-1:0] acc_c;

  always_comb begin
    acc_c   = dec.sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
    mul_res = dec.acc ? acc_c : prod;
  end
`else
  assign mul_res = prod;
`endif

  md_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .a   (a),
    .b   (b),
    .sign(dec.sgn),
    .quot(div_quot),
    .rem (div_rem)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && (dec.mul || dec.div)) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; start during RUN falls through to the hold defaults.
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    busy_d    = (state_d == ST_RUN);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dec.div) begin
            pend_hi_d = div_rem;
            pend_lo_d = div_quot;
            cnt_d     = CNT_W'(DIV_CYCLES);
          end else if (dec.mul) begin
            pend_hi_d = mul_res[PW-1:WIDTH];
            pend_lo_d = mul_res[WIDTH-1:0];
            cnt_d     = CNT_W'(MULT_CYCLES);
          end
          if (dec.mthi) hi_d = a;
          if (dec.mtlo) lo_d = a;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
